// File: rtl/m2_serial_adder_ctrl.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands and a carry-in,
// adds them LSB first on one 1-bit full-add cell, and hands the result out via valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// RUN   | one sum bit produced per clock, cnt tracks the bit index
// DONE  | result presented on out_valid_o until the consumer takes it
module m2_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry, cout_q;
    logic [CNT_W-1:0] cnt;

    logic             half_s, bit_sum, carry_nxt;
    logic [WIDTH-1:0] sum_sh_nxt;

    // Single add cell: two half-add stages, carries merged with an OR.
    assign half_s     = a_sh[0] ^ b_sh[0];
    assign bit_sum    = half_s ^ carry;
    assign carry_nxt  = (a_sh[0] & b_sh[0]) | (half_s & carry);
    assign sum_sh_nxt = {bit_sum, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid_i) state_nxt = RUN;
            RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_sh  <= a_i;
                        b_sh  <= b_i;
                        carry <= cin_i;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nxt;
                    sum_sh <= sum_sh_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    // Separate result register keeps the last delivered sum visible
                    // while the next operation is shifting through sum_sh.
                    if (cnt == CNT_LAST) begin
                        sum_q  <= sum_sh_nxt;
                        cout_q <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state == RUN) || (state == DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule

// File: tb/tb_m2_serial_adder_ctrl.sv
// Self-checking bench for m2_serial_adder_ctrl (WIDTH=8); expected results come from
// plain integer addition of the captured operands.
module tb_m2_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m2_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a_in),
        .b_i        (b_in),
        .cin_i      (cin),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .cout_o     (cout),
        .busy_o     (busy)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // Drives one operation and returns at the negedge where out_valid is first seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic orv, input bit churn,
                          output logic [W-1:0] s, output logic co,
                          output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        cin       = c;
        out_ready = orv;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
            if (churn) begin
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        s  = sum;
        co = cout;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: rdy/vld/busy/sum/cout got %b/%b/%b/%h/%b want 1/0/0/00/0",
                     in_ready, out_valid, busy, sum, cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [W-1:0] s;
        logic co;
        int lat;
        bit ok;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0, s, co, lat, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: out_valid never rose");
        end
        total++;
        if ({co, s} !== 9'h096) begin
            bad++;
            $display("FAIL basic_sum: got %b_%h want 0_96", co, s);
        end
        total++;
        if (lat !== W + 1) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_flags: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sum !== 8'h96 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_one_cycle: vld=%b sum=%h rdy=%b want 0/96/1", out_valid, sum, in_ready);
        end
    endtask

    task automatic test_carry;
        logic [W-1:0] s;
        logic co;
        int lat;
        bit ok;
        run_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h100) begin
            bad++;
            $display("FAIL carry_ff_01: got %b_%h ok=%0d want 1_00", co, s, ok);
        end
        run_op(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h1FF) begin
            bad++;
            $display("FAIL carry_ff_ff_1: got %b_%h ok=%0d want 1_ff", co, s, ok);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] s;
        logic co;
        int lat;
        bit ok;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h046) begin
            bad++;
            $display("FAIL bp_sum: got %b_%h ok=%0d want 0_46", co, s, ok);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: vld=%b sum=%h cout=%b rdy=%b want 1/46/0/0",
                         i, out_valid, sum, cout, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_churn;
        logic [W-1:0] s;
        logic co;
        int lat;
        bit ok;
        run_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b1, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h100 || lat !== W + 1) begin
            bad++;
            $display("FAIL churn: got %b_%h lat=%0d ok=%0d want 1_00 lat=%0d", co, s, lat, ok, W + 1);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] s;
        logic co;
        int lat;
        bit ok;
        @(negedge clk);
        in_valid  = 1'b1;
        a_in      = 8'hAA;
        b_in      = 8'h55;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_run: vld=%b sum=%h cout=%b rdy=%b busy=%b want 0/00/0/1/0",
                     out_valid, sum, cout, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h004 || lat !== W + 1) begin
            bad++;
            $display("FAIL rst_next_op: got %b_%h lat=%0d ok=%0d want 0_04 lat=%0d", co, s, lat, ok, W + 1);
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp_q[$];
        logic [W:0] exp;
        int n_acc = 0;
        int n_res = 0;
        int cyc = 0;
        int last_acc = -1;
        bit hs;
        int space_bad = 0;
        int data_bad = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = W'($urandom);
        b_in      = W'($urandom);
        cin       = 1'($urandom);
        while ((n_acc < 100 || n_res < 100) && cyc < 2000) begin
            hs = in_valid && in_ready;
            if (hs) begin
                exp_q.push_back(ref_add(a_in, b_in, cin));
                if (last_acc >= 0 && cyc - last_acc != W + 2) begin
                    space_bad++;
                    $display("FAIL b2b_spacing: acceptance gap %0d want %0d", cyc - last_acc, W + 2);
                end
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    data_bad++;
                    $display("FAIL b2b_extra: result %b_%h with nothing outstanding", cout, sum);
                end else begin
                    exp = exp_q.pop_front();
                    if ({cout, sum} !== exp) begin
                        data_bad++;
                        $display("FAIL b2b_data[%0d]: got %b_%h want %b_%h",
                                 n_res, cout, sum, exp[W], exp[W-1:0]);
                    end
                end
                n_res++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                cin  = 1'($urandom);
                if (n_acc == 100) in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (n_acc !== 100 || n_res !== 100 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count: accepted=%0d results=%0d left=%0d want 100/100/0",
                     n_acc, n_res, exp_q.size());
        end
        total++;
        if (space_bad !== 0) begin
            bad++;
            $display("FAIL b2b_spacing_total: bad gaps=%0d want 0", space_bad);
        end
        total++;
        if (data_bad !== 0) begin
            bad++;
            $display("FAIL b2b_data_total: bad results=%0d want 0", data_bad);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_churn;
        test_reset_mid_run;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
